branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised branch target buffer with 2-bit saturating direction counters for the next-generation five-stage pipeline. It predicts the next PC in IF, so fetch no longer waits for branch resolution in MEM. It is updated by the resolved instruction in MEM and raises a mispredict and redirect when the carried prediction was wrong. This replaces the fixed "predict not-taken, flush on npcc" scheme and exports hit and mispredict statistics for the test programs.

## Interface
Parameters:
- ENTRIES, 16: number of BTB entries; power of two, minimum 2.
- IDX_W, 4: log2(ENTRIES).
- TAG_W, 8: tag bits stored per entry.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clr  in  1  synchronous, active-high reset.
- pcF  in  32  fetch PC.
- predTakenF  out  1  prediction for pcF.
- predTargetF  out  32  predicted next PC for pcF.
- instValidM  in  1  a real (non-bubble) instruction is in MEM.
- isCtlM  in  1  the MEM instruction is a branch, j, jal or jr.
- isJumpM  in  1  the MEM instruction is unconditional (j, jal, jr).
- pcM  in  32  PC of the MEM instruction.
- takenM  in  1  resolved direction.
- targetM  in  32  resolved target.
- predTakenM  in  1  prediction carried down the pipe from IF.
- predTargetM  in  32  predicted target carried down the pipe from IF.
- mispredictM  out  1  flush IF/ID/EX and redirect fetch.
- redirectPcM  out  32  correct next PC when mispredictM=1.
- ctlCnt  out  32  count of resolved control instructions.
- missCnt  out  32  count of mispredicts.

## Operation
- Index is pc[IDX_W+1:2]. Tag is pc[IDX_W+TAG_W+1:IDX_W+2].
- Each entry holds valid, tag[TAG_W], target[32] and ctr[2].
- Lookup is combinational from the registered table. hit = valid & tag match. predTakenF = hit & ctr[1]. predTargetF = predTakenF ? target : pcF+4 (mod 2^32).
- Update is active when instValidM & isCtlM:
  - Hit, taken: ctr increments, saturating at 3. target is written with targetM.
  - Hit, not taken: ctr decrements, saturating at 0. target is left unchanged.
  - Miss, taken: allocate (overwriting the entry), set valid=1, write tag and target. ctr=3 if isJumpM, otherwise ctr=2.
  - Miss, not taken: no change.
  - isJumpM hit: ctr is forced to 3.
- Alias cleanup: when instValidM & !isCtlM & predTakenM, the entry at the index of pcM is invalidated if its tag matches pcM.
- mispredictM = instValidM & one of the following:
  - isCtlM & (predTakenM != takenM);
  - isCtlM & takenM & predTakenM & (predTargetM != targetM);
  - !isCtlM & predTakenM.
- redirectPcM = (isCtlM & takenM) ? targetM : pcM+4. It is valid only while mispredictM=1.
- ctlCnt increments on every update event. missCnt increments whenever mispredictM=1. Both saturate at 32'hFFFFFFFF.
- instValidM=0 blocks all updates, counts and mispredicts.

## Timing
- Reset (clr=1 at an edge): every valid=0, every ctr=1, ctlCnt=0, missCnt=0. Tag and target contents are don't-care.
- Effect of reset on outputs: combinational outputs follow the cleared state immediately after the edge. predTakenF=0, predTargetF=pcF+4, mispredictM depends only on the current inputs.
- clr has priority over a same-cycle update. Reset mid-stream drops the pending update and counter increments.
- Lookup latency is 0 cycles. An update written at edge N is visible to a lookup in cycle N+1.
- Same-index lookup and update in one cycle: the lookup returns the pre-update contents (read-before-write).
- Update and alias invalidate can never coincide, because they require opposite isCtlM.
- mispredictM and redirectPcM are combinational in the MEM cycle. The hazard unit registers the flush.
- pcF+4 and pcM+4 wrap modulo 2^32: 32'hFFFFFFFC+4 = 0.

## Test plan
- Reset: assert clr for 1 cycle, then pcF=0x40 -> predTakenF=0, predTargetF=0x44, ctlCnt=0, missCnt=0.
- Cold taken branch: pcM=0x40, takenM=1, targetM=0x80, predTakenM=0 -> mispredictM=1, redirectPcM=0x80, missCnt=1. Next cycle pcF=0x40 -> predTakenF=1, predTargetF=0x80.
- Hysteresis: from ctr=2, resolve not-taken once -> ctr=1 and mispredict. Then resolve taken twice -> ctr=3. A single not-taken from 3 -> predTakenF remains 1.
- Alias: entry at 0x40 is valid and a non-control instruction with pcM=0x40 and predTakenM=1 arrives -> mispredictM=1, redirectPcM=0x44, entry invalidated, next lookup of 0x40 is not taken.
- Target change: jr at 0x100 predicted to 0x200, actual 0x300 -> mispredictM=1, redirectPcM=0x300, stored target becomes 0x300.
- Same cycle: pcF=pcM=0x40 with an allocating update -> predTakenF=0 this cycle and 1 the next. With clr asserted in the same cycle -> no allocation, ctlCnt=0.

Source files
------------

// File: rtl/branch_predictor.sv
// Branch target buffer with 2-bit saturating direction counters.
// IF does a zero-latency lookup on pcF. The resolved instruction in MEM updates the table,
// detects mispredicts and supplies the redirect PC. Hit/mispredict statistics are exported.
module branch_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned TAG_W   = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] pcF,
    output logic        predTakenF,
    output logic [31:0] predTargetF,
    input  logic        instValidM,
    input  logic        isCtlM,
    input  logic        isJumpM,
    input  logic [31:0] pcM,
    input  logic        takenM,
    input  logic [31:0] targetM,
    input  logic        predTakenM,
    input  logic [31:0] predTargetM,
    output logic        mispredictM,
    output logic [31:0] redirectPcM,
    output logic [31:0] ctlCnt,
    output logic [31:0] missCnt
);

    localparam int unsigned TAG_LO = IDX_W + 2;
    localparam int unsigned TAG_HI = IDX_W + TAG_W + 1;

    // Table storage, one row per entry
    logic [ENTRIES-1:0]             valid_q;
    logic [ENTRIES-1:0][TAG_W-1:0]  tag_q;
    logic [ENTRIES-1:0][31:0]       target_q;
    logic [ENTRIES-1:0][1:0]        ctr_q;

    logic [31:0] ctl_cnt_q;
    logic [31:0] miss_cnt_q;

    logic [IDX_W-1:0] idx_f;
    logic [TAG_W-1:0] tag_f;
    logic             hit_f;

    logic [IDX_W-1:0] idx_m;
    logic [TAG_W-1:0] tag_m;
    logic             hit_m;
    logic             upd_en;
    logic             alias_en;

    logic             ent_we;
    logic             ent_valid_d;
    logic [TAG_W-1:0] ent_tag_d;
    logic [31:0]      ent_target_d;
    logic [1:0]       ent_ctr_d;

    // PC bits outside the index/tag fields carry no information for the table
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pcF[1:0], pcF[31:TAG_HI+1], pcM[1:0], pcM[31:TAG_HI+1]};

    assign idx_f = pcF[IDX_W+1:2];
    assign tag_f = pcF[TAG_HI:TAG_LO];
    assign idx_m = pcM[IDX_W+1:2];
    assign tag_m = pcM[TAG_HI:TAG_LO];

    // Fetch-side lookup from the registered table (read-before-write on a same-cycle update)
    always_comb begin
        hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
        predTakenF  = hit_f & ctr_q[idx_f][1];
        predTargetF = predTakenF ? target_q[idx_f] : pcF + 32'd4;
    end

    // MEM-side next-entry computation: counter training, allocation and alias invalidation
    always_comb begin
        upd_en       = instValidM & isCtlM;
        alias_en     = instValidM & ~isCtlM & predTakenM;
        hit_m        = valid_q[idx_m] && (tag_q[idx_m] == tag_m);
        ent_we       = 1'b0;
        ent_valid_d  = valid_q[idx_m];
        ent_tag_d    = tag_q[idx_m];
        ent_target_d = target_q[idx_m];
        ent_ctr_d    = ctr_q[idx_m];
        if (upd_en) begin
            if (hit_m) begin
                ent_we = 1'b1;
                if (isJumpM) begin
                    ent_ctr_d = 2'd3;
                end else if (takenM) begin
                    ent_ctr_d = (ctr_q[idx_m] == 2'd3) ? 2'd3 : ctr_q[idx_m] + 2'd1;
                end else begin
                    ent_ctr_d = (ctr_q[idx_m] == 2'd0) ? 2'd0 : ctr_q[idx_m] - 2'd1;
                end
                if (takenM) begin
                    ent_target_d = targetM;
                end
            end else if (takenM) begin
                ent_we       = 1'b1;
                ent_valid_d  = 1'b1;
                ent_tag_d    = tag_m;
                ent_target_d = targetM;
                ent_ctr_d    = isJumpM ? 2'd3 : 2'd2;
            end
        end else if (alias_en && hit_m) begin
            // A non-control instruction was predicted taken: drop the stale entry
            ent_we      = 1'b1;
            ent_valid_d = 1'b0;
        end
    end

    // Mispredict detection and the correct fetch address
    always_comb begin
        mispredictM = instValidM &
                      ((isCtlM & (predTakenM != takenM)) |
                       (isCtlM & takenM & predTakenM & (predTargetM != targetM)) |
                       (~isCtlM & predTakenM));
        redirectPcM = (isCtlM & takenM) ? targetM : pcM + 32'd4;
    end

    // Valid bits and counters: cleared by reset, reset wins over a same-cycle update
    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q <= '0;
            ctr_q   <= {ENTRIES{2'd1}};
        end else if (ent_we) begin
            valid_q[idx_m] <= ent_valid_d;
            ctr_q[idx_m]   <= ent_ctr_d;
        end
    end

    // Tag and target payload, not reset
    always_ff @(posedge clk) begin
        if (!clr && ent_we) begin
            tag_q[idx_m]    <= ent_tag_d;
            target_q[idx_m] <= ent_target_d;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk) begin
        if (clr) begin
            ctl_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (upd_en && (ctl_cnt_q != 32'hFFFF_FFFF)) begin
                ctl_cnt_q <= ctl_cnt_q + 32'd1;
            end
            if (mispredictM && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign ctlCnt  = ctl_cnt_q;
    assign missCnt = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table followed by a randomized
// run against a behavioural model of the predictor table.
module tb_branch_predictor;

    localparam int unsigned ENTRIES = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned TAG_W   = 8;
    localparam int          NRAND   = 3000;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] pcF;
    logic        predTakenF;
    logic [31:0] predTargetF;
    logic        instValidM;
    logic        isCtlM;
    logic        isJumpM;
    logic [31:0] pcM;
    logic        takenM;
    logic [31:0] targetM;
    logic        predTakenM;
    logic [31:0] predTargetM;
    logic        mispredictM;
    logic [31:0] redirectPcM;
    logic [31:0] ctlCnt;
    logic [31:0] missCnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_predictor #(
        .ENTRIES(ENTRIES),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .pcF        (pcF),
        .predTakenF (predTakenF),
        .predTargetF(predTargetF),
        .instValidM (instValidM),
        .isCtlM     (isCtlM),
        .isJumpM    (isJumpM),
        .pcM        (pcM),
        .takenM     (takenM),
        .targetM    (targetM),
        .predTakenM (predTakenM),
        .predTargetM(predTargetM),
        .mispredictM(mispredictM),
        .redirectPcM(redirectPcM),
        .ctlCnt     (ctlCnt),
        .missCnt    (missCnt)
    );

    typedef struct {
        logic        clr;
        logic [31:0] pcf;
        logic        v;
        logic        ctl;
        logic        jmp;
        logic [31:0] pcm;
        logic        tk;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic        chk;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_mis;
        logic [31:0] e_rpc;
        logic [31:0] e_ctl;
        logic [31:0] e_miss;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic c, input logic [31:0] pf, input logic v, input logic ct,
                                input logic j, input logic [31:0] pm, input logic tk,
                                input logic [31:0] tg, input logic ptk, input logic [31:0] ptg,
                                input logic chk, input logic ept, input logic [31:0] eptg,
                                input logic emis, input logic [31:0] erpc,
                                input logic [31:0] ectl, input logic [31:0] emiss);
        vec_t r;
        r.clr = c;  r.pcf = pf;  r.v = v;  r.ctl = ct;  r.jmp = j;  r.pcm = pm;
        r.tk = tk;  r.tgt = tg;  r.ptk = ptk;  r.ptgt = ptg;  r.chk = chk;
        r.e_pt = ept;  r.e_ptgt = eptg;  r.e_mis = emis;  r.e_rpc = erpc;
        r.e_ctl = ectl;  r.e_miss = emiss;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t r);
        clr         = r.clr;
        pcF         = r.pcf;
        instValidM  = r.v;
        isCtlM      = r.ctl;
        isJumpM     = r.jmp;
        pcM         = r.pcm;
        takenM      = r.tk;
        targetM     = r.tgt;
        predTakenM  = r.ptk;
        predTargetM = r.ptgt;
    endtask

    // Behavioural model: table as plain arrays with integer saturating counters
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    longint      m_ctl;
    longint      m_miss;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return (pc / (4 * ENTRIES)) % (1 << TAG_W);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_ctl  = 0;
        m_miss = 0;
    endtask

    task automatic m_predict(input logic [31:0] pc, output logic pt, output logic [31:0] ptg);
        pt  = m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
        ptg = pt ? m_tgt[idx_of(pc)] : pc + 32'd4;
    endtask

    function automatic bit m_mispredict(input vec_t r);
        if (!r.v) return 1'b0;
        if (r.ctl && (r.ptk != r.tk)) return 1'b1;
        if (r.ctl && r.tk && r.ptk && (r.ptgt != r.tgt)) return 1'b1;
        if (!r.ctl && r.ptk) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_step(input vec_t r);
        int unsigned i;
        bit          h;
        if (r.clr) begin
            m_reset();
            return;
        end
        if (!r.v) return;
        if (m_mispredict(r) && m_miss < 64'hFFFF_FFFF) m_miss++;
        i = idx_of(r.pcm);
        h = m_hit(r.pcm);
        if (r.ctl) begin
            if (m_ctl < 64'hFFFF_FFFF) m_ctl++;
            if (h) begin
                if (r.jmp) m_ctr[i] = 3;
                else if (r.tk) m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                else m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
                if (r.tk) m_tgt[i] = r.tgt;
            end else if (r.tk) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(r.pcm);
                m_tgt[i]   = r.tgt;
                m_ctr[i]   = r.jmp ? 3 : 2;
            end
        end else if (r.ptk && h) begin
            m_valid[i] = 1'b0;
        end
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        case ($urandom_range(0, 7))
            0:       p = $urandom & 32'hFFFF_FFFC;
            1:       p = 32'hFFFF_FFFC;
            default: p = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 7) << 2);
        endcase
        return p;
    endfunction

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        case ($urandom_range(0, 3))
            0: t = 32'h80;
            1: t = 32'h200;
            2: t = 32'h300;
            default: t = $urandom & 32'hFFFF_FFFC;
        endcase
        return t;
    endfunction

    initial begin
        vec_t        r;
        logic        e_pt;
        logic [31:0] e_ptg;
        logic        e_mis;

        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Directed sequence; counts are those before the row's clock edge
        vecs.push_back(mk(1, 'h40, 0, 0, 0, 'h0, 0, 'h0, 0, 'h0, 0, 0, 'h0, 0, 'h0, 0, 0));
        vecs.push_back(mk(0, 'h40, 0, 0, 0, 'h0, 0, 'h0, 0, 'h0, 1, 0, 'h44, 0, 'h0, 0, 0));
        vecs.push_back(mk(0, 'h40, 1, 1, 0, 'h40, 1, 'h80, 0, 'h44, 1, 0, 'h44, 1, 'h80, 0, 0));
        vecs.push_back(mk(0, 'h40, 0, 0, 0, 'h0, 0, 'h0, 0, 'h0, 1, 1, 'h80, 0, 'h0, 1, 1));
        vecs.push_back(mk(0, 'h40, 1, 1, 0, 'h40, 0, 'h80, 1, 'h80, 1, 1, 'h80, 1, 'h44, 1, 1));
        vecs.push_back(mk(0, 'h40, 1, 1, 0, 'h40, 1, 'h80, 0, 'h44, 1, 0, 'h44, 1, 'h80, 2, 2));
        vecs.push_back(mk(0, 'h40, 1, 1, 0, 'h40, 1, 'h80, 1, 'h80, 1, 1, 'h80, 0, 'h0, 3, 3));
        vecs.push_back(mk(0, 'h40, 1, 1, 0, 'h40, 0, 'h80, 1, 'h80, 1, 1, 'h80, 1, 'h44, 4, 3));
        vecs.push_back(mk(0, 'h40, 0, 0, 0, 'h0, 0, 'h0, 0, 'h0, 1, 1, 'h80, 0, 'h0, 5, 4));
        vecs.push_back(mk(0, 'h40, 1, 0, 0, 'h40, 0, 'h0, 1, 'h80, 1, 1, 'h80, 1, 'h44, 5, 4));
        vecs.push_back(mk(0, 'h40, 0, 0, 0, 'h0, 0, 'h0, 0, 'h0, 1, 0, 'h44, 0, 'h0, 5, 5));
        vecs.push_back(mk(0, 'h100, 1, 1, 1, 'h100, 1, 'h200, 0, 'h104, 1, 0, 'h104, 1, 'h200,
                          5, 5));
        vecs.push_back(mk(0, 'h100, 1, 1, 1, 'h100, 1, 'h300, 1, 'h200, 1, 1, 'h200, 1, 'h300,
                          6, 6));
        vecs.push_back(mk(0, 'h100, 0, 0, 0, 'h0, 0, 'h0, 0, 'h0, 1, 1, 'h300, 0, 'h0, 7, 7));
        vecs.push_back(mk(0, 'hFFFF_FFFC, 1, 0, 0, 'hFFFF_FFFC, 0, 'h0, 1, 'h80, 1, 0, 'h0, 1,
                          'h0, 7, 7));
        vecs.push_back(mk(1, 'h40, 1, 1, 0, 'h40, 1, 'h80, 0, 'h44, 1, 0, 'h44, 1, 'h80, 7, 8));
        vecs.push_back(mk(0, 'h40, 0, 0, 0, 'h0, 0, 'h0, 0, 'h0, 1, 0, 'h44, 0, 'h0, 0, 0));
        vecs.push_back(mk(0, 'h100, 0, 0, 0, 'h0, 0, 'h0, 0, 'h0, 1, 0, 'h104, 0, 'h0, 0, 0));

        foreach (vecs[k]) begin
            @(posedge clk);
            #1;
            drive(vecs[k]);
            @(negedge clk);
            if (vecs[k].chk) begin
                check($sformatf("row%0d predTakenF", k), predTakenF, vecs[k].e_pt);
                check($sformatf("row%0d predTargetF", k), predTargetF, vecs[k].e_ptgt);
                check($sformatf("row%0d mispredictM", k), mispredictM, vecs[k].e_mis);
                if (vecs[k].e_mis)
                    check($sformatf("row%0d redirectPcM", k), redirectPcM, vecs[k].e_rpc);
                check($sformatf("row%0d ctlCnt", k), ctlCnt, vecs[k].e_ctl);
                check($sformatf("row%0d missCnt", k), missCnt, vecs[k].e_miss);
            end
        end

        // Randomized run against the model, starting from a fresh reset
        @(posedge clk);
        #1;
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        m_reset();
        for (int n = 0; n < NRAND; n++) begin
            @(posedge clk);
            #1;
            r.clr = ($urandom_range(0, 99) == 0);
            r.pcf = rand_pc();
            r.v   = ($urandom_range(0, 4) != 0);
            r.ctl = $urandom_range(0, 2) != 0;
            r.jmp = r.ctl && ($urandom_range(0, 3) == 0);
            r.pcm = ($urandom_range(0, 1) == 0) ? r.pcf : rand_pc();
            r.tk  = r.jmp ? 1'b1 : 1'($urandom_range(0, 1));
            r.tgt = rand_tgt();
            if ($urandom_range(0, 1) == 0) begin
                m_predict(r.pcm, r.ptk, r.ptgt);
            end else begin
                r.ptk  = 1'($urandom_range(0, 1));
                r.ptgt = rand_tgt();
            end
            r.chk = 1'b1;
            drive(r);
            @(negedge clk);
            m_predict(r.pcf, e_pt, e_ptg);
            e_mis = m_mispredict(r);
            check("rnd predTakenF", predTakenF, e_pt);
            check("rnd predTargetF", predTargetF, e_ptg);
            check("rnd mispredictM", mispredictM, e_mis);
            if (e_mis)
                check("rnd redirectPcM", redirectPcM, (r.ctl && r.tk) ? r.tgt : r.pcm + 32'd4);
            check("rnd ctlCnt", ctlCnt, m_ctl[31:0]);
            check("rnd missCnt", missCnt, m_miss[31:0]);
            m_step(r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
